pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_pkg.sv | 17 +
 rtl/pc_redirect_buf.sv | 30 +++
 rtl/pc_unit.sv | 132 +++++++++++++
 tb/tb_pc_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: FSM state encoding and
// default vectors used by pc_unit and pc_redirect_buf.
package pc_pkg;

    // FSM state encoding (kept as plain constants for legacy tool flows)
    typedef logic [1:0] pc_state_t;
    localparam pc_state_t BOOT = 2'd0;
    localparam pc_state_t RUN  = 2'd1;
    localparam pc_state_t HOLD = 2'd2;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0040_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0040_0004;

    // Low PC bits that must be zero in any loaded target
    localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry pending-redirect register. A capture loads (or overwrites) the
// stored target; a clear drops it and wins over a simultaneous capture.
module pc_redirect_buf
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             capture,
    input  logic [WIDTH-1:0] capture_target,
    input  logic             clear,
    output logic             valid,
    output logic [WIDTH-1:0] target
);

    // Hold the most recent captured redirect until it is consumed or cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid  <= 1'b0;
            target <= '0;
        end else if (clear) begin
            valid  <= 1'b0;
        end else if (capture) begin
            valid  <= 1'b1;
            target <= capture_target;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: sequential fetch-address generation with redirect,
// stall/backpressure hold and a one-entry pending redirect.
// Optional exception PC support is enabled by defining PC_UNIT_EPC_EN.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
    parameter int unsigned      STEP         = 4
`ifdef PC_UNIT_EPC_EN
    ,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEFAULT_EXC_VECTOR)
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             fetch_ready,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
`ifdef PC_UNIT_EPC_EN
    input  logic             exc_req,
    input  logic             eret,
    output logic [WIDTH-1:0] epc_out,
`endif
    output logic [WIDTH-1:0] pc_out,
    output logic             pc_valid,
    output logic             misalign
);

    pc_state_t        state_q, state_d;
    logic [WIDTH-1:0] pc_d;
    logic             misalign_d;
    logic             hold;
    logic             live_valid;
    logic [WIDTH-1:0] live_target_raw;
    logic [WIDTH-1:0] live_target;
    logic             live_take;
    logic             pend_valid;
    logic [WIDTH-1:0] pend_target;
    logic             pend_capture;
    logic             pend_clear;

`ifdef PC_UNIT_EPC_EN
    logic [WIDTH-1:0] epc_q;

    // eret behaves as a live redirect back past the excepting instruction
    assign live_valid      = redirect_valid | eret;
    assign live_target_raw = eret ? epc_q + WIDTH'(STEP) : redirect_target;
    assign epc_out         = epc_q;

    // Record the PC of the instruction taking the exception
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            epc_q <= '0;
        end else if (exc_req) begin
            epc_q <= pc_out;
        end
    end
`else
    assign live_valid      = redirect_valid;
    assign live_target_raw = redirect_target;
`endif

    assign pc_valid    = (state_q != BOOT);
    assign hold        = stall | (pc_valid & ~fetch_ready);
    assign live_target = {live_target_raw[WIDTH-1:2], live_target_raw[1:0] & ~ALIGN_MASK};
    // Outside HOLD only stall blocks a redirect; inside HOLD it must see the exit condition
    assign live_take   = live_valid & ~stall & ((state_q != HOLD) | fetch_ready);

    // Next PC / state selection in priority order
    always_comb begin
        pc_d         = pc_out;
        state_d      = state_q;
        pend_capture = 1'b0;
        pend_clear   = 1'b0;
        misalign_d   = 1'b0;
`ifdef PC_UNIT_EPC_EN
        if (exc_req) begin
            pc_d       = EXC_VECTOR;
            pend_clear = 1'b1;
            state_d    = RUN;
        end else
`endif
        begin
            misalign_d = live_valid & (|(live_target_raw[1:0] & ALIGN_MASK));
            if (live_take) begin
                pc_d       = live_target;
                pend_clear = 1'b1;
                state_d    = RUN;
            end else if (hold) begin
                pend_capture = live_valid;
                state_d      = (state_q == BOOT) ? RUN : HOLD;
            end else if (pend_valid) begin
                pc_d       = pend_target;
                pend_clear = 1'b1;
                state_d    = RUN;
            end else if (pc_valid) begin
                pc_d    = pc_out + WIDTH'(STEP);
                state_d = RUN;
            end else begin
                state_d = RUN;
            end
        end
    end

    // PC, FSM state and misalign pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= BOOT;
            pc_out   <= RESET_VECTOR;
            misalign <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_out   <= pc_d;
            misalign <= misalign_d;
        end
    end

    pc_redirect_buf #(
        .WIDTH(WIDTH)
    ) u_redirect_buf (
        .clk            (clk),
        .rst_n          (rst_n),
        .capture        (pend_capture),
        .capture_target (live_target),
        .clear          (pend_clear),
        .valid          (pend_valid),
        .target         (pend_target)
    );

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit (32-bit instance plus a 16-bit
// instance for the wrap case). Expected values are queued when stimulus is
// driven and popped when the edge has produced the DUT response.
module tb_pc_unit;

    localparam logic [31:0] RV = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        fetch_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic [31:0] pc_out;
    logic        pc_valid;
    logic        misalign;
    logic [15:0] pc16;
    logic        valid16;
    logic        mis16;
`ifdef PC_UNIT_EPC_EN
    logic        exc_req = 1'b0;
    logic        eret = 1'b0;
    logic [31:0] epc_out;
    logic [15:0] epc16;
`endif

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic        mis;
        bit          chk16;
        logic [15:0] pc16;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pc_unit u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .fetch_ready     (fetch_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
`ifdef PC_UNIT_EPC_EN
        .exc_req         (exc_req),
        .eret            (eret),
        .epc_out         (epc_out),
`endif
        .pc_out          (pc_out),
        .pc_valid        (pc_valid),
        .misalign        (misalign)
    );

    pc_unit #(
        .WIDTH(16)
    ) u_dut16 (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .fetch_ready     (fetch_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target[15:0]),
`ifdef PC_UNIT_EPC_EN
        .exc_req         (exc_req),
        .eret            (eret),
        .epc_out         (epc16),
`endif
        .pc_out          (pc16),
        .pc_valid        (valid16),
        .misalign        (mis16)
    );

    task automatic check_now(input string tag, input logic [31:0] e_pc, input logic e_valid,
                             input logic e_mis);
        n_vec++;
        assert (pc_out === e_pc) else begin
            n_err++;
            $error("FAIL %s pc_out got %h want %h", tag, pc_out, e_pc);
        end
        n_vec++;
        assert (pc_valid === e_valid) else begin
            n_err++;
            $error("FAIL %s pc_valid got %b want %b", tag, pc_valid, e_valid);
        end
        n_vec++;
        assert (misalign === e_mis) else begin
            n_err++;
            $error("FAIL %s misalign got %b want %b", tag, misalign, e_mis);
        end
    endtask

    // Entered and left at a falling edge; drives one cycle of stimulus
    task automatic cyc(input string tag, input logic s, input logic r, input logic rv,
                       input logic [31:0] t, input logic [31:0] e_pc, input logic e_valid,
                       input logic e_mis, input bit c16, input logic [15:0] e16);
        exp_t e;
        stall           = s;
        fetch_ready     = r;
        redirect_valid  = rv;
        redirect_target = t;
        e.pc    = e_pc;
        e.valid = e_valid;
        e.mis   = e_mis;
        e.chk16 = c16;
        e.pc16  = e16;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_now(tag, e.pc, e.valid, e.mis);
        if (e.chk16) begin
            n_vec++;
            assert (pc16 === e.pc16 && valid16 === 1'b1 && mis16 === 1'b0) else begin
                n_err++;
                $error("FAIL %s pc16 got %h/%b/%b want %h/1/0", tag, pc16, valid16, mis16,
                       e.pc16);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        fetch_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_now("reset", RV, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        check_now("boot", RV, 1'b0, 1'b0);

        // Boot then sequential stepping
        cyc("boot_run", 0, 1, 0, 32'h0, RV,                1, 0, 0, 16'h0);
        cyc("seq1",     0, 1, 0, 32'h0, RV + 32'h4,        1, 0, 0, 16'h0);
        cyc("seq2",     0, 1, 0, 32'h0, RV + 32'h8,        1, 0, 0, 16'h0);

        // Redirects, aligned and misaligned
        cyc("redir",    0, 1, 1, 32'h0040_0100, 32'h0040_0100, 1, 0, 0, 16'h0);
        cyc("after_r",  0, 1, 0, 32'h0,         32'h0040_0104, 1, 0, 0, 16'h0);
        cyc("mis_redir",0, 1, 1, 32'h0040_0102, 32'h0040_0100, 1, 1, 0, 16'h0);
        cyc("mis_end",  0, 1, 0, 32'h0,         32'h0040_0104, 1, 0, 0, 16'h0);

        // Backpressure
        cyc("bp1",      0, 0, 0, 32'h0, 32'h0040_0104, 1, 0, 0, 16'h0);
        cyc("bp2",      0, 0, 0, 32'h0, 32'h0040_0104, 1, 0, 0, 16'h0);
        cyc("bp_go1",   0, 1, 0, 32'h0, 32'h0040_0108, 1, 0, 0, 16'h0);
        cyc("bp_go2",   0, 1, 0, 32'h0, 32'h0040_010C, 1, 0, 0, 16'h0);

        // Pending redirect captured during stall, overwritten, applied on release
        cyc("st_r1",    1, 1, 1, 32'h0040_0200, 32'h0040_010C, 1, 0, 0, 16'h0);
        cyc("st_r2",    1, 1, 1, 32'h0040_0300, 32'h0040_010C, 1, 0, 0, 16'h0);
        cyc("st_3",     1, 1, 0, 32'h0,         32'h0040_010C, 1, 0, 0, 16'h0);
        cyc("st_rel",   0, 1, 0, 32'h0,         32'h0040_0300, 1, 0, 0, 16'h0);
        cyc("st_seq",   0, 1, 0, 32'h0,         32'h0040_0304, 1, 0, 0, 16'h0);

        // Live redirect on exit beats pending; pending is then gone
        cyc("lv_st",    1, 1, 1, 32'h0040_0400, 32'h0040_0304, 1, 0, 0, 16'h0);
        cyc("lv_exit",  0, 1, 1, 32'h0040_0500, 32'h0040_0500, 1, 0, 0, 16'h0);
        cyc("lv_seq",   0, 1, 0, 32'h0,         32'h0040_0504, 1, 0, 0, 16'h0);

        // Redirect in RUN ignores fetch_ready
        cyc("rd_nrdy",  0, 0, 1, 32'h0040_0600, 32'h0040_0600, 1, 0, 0, 16'h0);
        cyc("rd_seq",   0, 1, 0, 32'h0,         32'h0040_0604, 1, 0, 0, 16'h0);

        // Reset mid-HOLD with a pending redirect discards it
        cyc("hold_pend",1, 1, 1, 32'h0040_0700, 32'h0040_0604, 1, 0, 0, 16'h0);
        #2;
        rst_n          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        #1;
        check_now("rst_async", RV, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc("rst_run",  0, 1, 0, 32'h0, RV,         1, 0, 0, 16'h0);
        cyc("rst_seq",  0, 1, 0, 32'h0, RV + 32'h4, 1, 0, 0, 16'h0);

        // Wrap at the top of a 16-bit address space
        cyc("wrap_tgt", 0, 1, 1, 32'h0000_FFFC, 32'h0000_FFFC, 1, 0, 1, 16'hFFFC);
        cyc("wrap",     0, 1, 0, 32'h0,         32'h0001_0000, 1, 0, 1, 16'h0000);

`ifdef PC_UNIT_EPC_EN
        cyc("epc_tgt",  0, 1, 1, 32'h0040_0010, 32'h0040_0010, 1, 0, 0, 16'h0);
        exc_req = 1'b1;
        cyc("exc",      0, 1, 0, 32'h0,         32'h0040_0004, 1, 0, 0, 16'h0);
        exc_req = 1'b0;
        n_vec++;
        assert (epc_out === 32'h0040_0010) else begin
            n_err++;
            $error("FAIL epc got %h want %h", epc_out, 32'h0040_0010);
        end
        eret = 1'b1;
        cyc("eret",     0, 1, 0, 32'h0,         32'h0040_0014, 1, 0, 0, 16'h0);
        eret = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
